// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Result is computed from operands sampled at Start and committed only when Busy ends.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [2:0]  MDU_Sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HI_En,
    input  logic        LO_En,
    input  logic        MDU_Out_Sel,
    output logic        Busy,
    output logic        Busy_Start,
    output logic [31:0] MDU_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_skip;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_tempHi;
    logic [31:0]   r_tempLo;

    logic          w_startOk;
    logic          w_isDiv;
    logic          w_divZero;
    logic [63:0]   w_prodS;
    logic [63:0]   w_prodU;
    logic [31:0]   w_absA;
    logic [31:0]   w_absB;
    logic [31:0]   w_divB;
    logic [31:0]   w_magQ;
    logic [31:0]   w_magR;
    logic [31:0]   w_quotS;
    logic [31:0]   w_remS;
    logic [31:0]   w_resHi;
    logic [31:0]   w_resLo;

    assign w_startOk = Start & ~MDU_Sel[2];
    assign w_isDiv   = MDU_Sel[1];
    assign w_divZero = (B == 32'd0);

    assign w_prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prodU = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes so -2^31 / -1 never overflows the divider.
    assign w_absA  = A[31] ? (~A + 32'd1) : A;
    assign w_absB  = B[31] ? (~B + 32'd1) : B;
    assign w_divB  = w_divZero ? 32'd1 : w_absB;
    assign w_magQ  = w_absA / w_divB;
    assign w_magR  = w_absA % w_divB;
    assign w_quotS = (A[31] ^ B[31]) ? (~w_magQ + 32'd1) : w_magQ;
    assign w_remS  = A[31] ? (~w_magR + 32'd1) : w_magR;

    always_comb begin
        w_resHi = 32'd0;
        w_resLo = 32'd0;
        case (MDU_Sel[1:0])
            2'd0: begin
                w_resHi = w_prodS[63:32];
                w_resLo = w_prodS[31:0];
            end
            2'd1: begin
                w_resHi = w_prodU[63:32];
                w_resLo = w_prodU[31:0];
            end
            2'd2: begin
                w_resHi = w_remS;
                w_resLo = w_quotS;
            end
            default: begin
                w_resHi = A % w_divB;
                w_resLo = A / w_divB;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_skip   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tempHi <= 32'd0;
            r_tempLo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_startOk) begin
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                        r_count  <= w_isDiv ? DIV_LOAD : MULT_LOAD;
                        r_skip   <= w_isDiv & w_divZero;
                        r_tempHi <= w_resHi;
                        r_tempLo <= w_resLo;
                    end else begin
                        if (HI_En) r_hi <= A;
                        if (LO_En) r_lo <= A;
                    end
                end
                default: begin
                    // Start and mthi/mtlo are deliberately ignored until the op retires.
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!r_skip) begin
                            r_hi <= r_tempHi;
                            r_lo <= r_tempLo;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            endcase
        end
    end

    assign Busy       = r_busy;
    assign Busy_Start = r_busy | Start;
    assign MDU_Out    = MDU_Out_Sel ? r_hi : r_lo;

endmodule
